// File: rtl/sha256d_sequencer.sv
// Control and H0..H7 chaining state for SHA-256d of an 80-byte block header.
// Sequences three blocks: header block 0, header block 1, then the padded first digest.
module sha256d_sequencer #(
    parameter int ROUNDS = 64,
    parameter int RW     = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [255:0]  hash_values,
    input  logic [255:0]  work_state,
    output logic          busy,
    output logic          done,
    output logic          hash_sel,
    output logic          block_sel,
    output logic          state_load,
    output logic [255:0]  state_init,
    output logic          round_en,
    output logic [RW-1:0] round_idx,
    output logic [255:0]  digest1,
    output logic [255:0]  final_hash
);

    typedef enum logic [2:0] {IDLE, INIT, ROUND, ACCUM, DONE} state_t;

    state_t        state_q, state_d;
    logic [255:0]  h_q, h_d;
    logic [255:0]  digest1_q, digest1_d;
    logic [255:0]  final_q, final_d;
    logic          hash_sel_q, hash_sel_d;
    logic          block_sel_q, block_sel_d;
    logic [RW-1:0] round_q, round_d;
    logic [255:0]  sum;
    logic          last_round;

    // Feed-forward: eight independent 32-bit adds, no carry between words.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sum[32*i +: 32] = h_q[32*i +: 32] + work_state[32*i +: 32];
        end
    end

    assign last_round = (round_q == RW'(ROUNDS - 1));

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        digest1_d   = digest1_q;
        final_d     = final_q;
        hash_sel_d  = hash_sel_q;
        block_sel_d = block_sel_q;
        round_d     = round_q;
        busy        = 1'b0;
        done        = 1'b0;
        state_load  = 1'b0;
        round_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    h_d         = hash_values;
                    hash_sel_d  = 1'b0;
                    block_sel_d = 1'b0;
                    round_d     = '0;
                    state_d     = INIT;
                end
            end
            INIT: begin
                busy       = 1'b1;
                state_load = 1'b1;
                round_d    = '0;
                state_d    = ROUND;
            end
            ROUND: begin
                busy     = 1'b1;
                round_en = 1'b1;
                if (last_round) begin
                    round_d = '0;
                    state_d = ACCUM;
                end else begin
                    round_d = round_q + RW'(1);
                end
            end
            ACCUM: begin
                busy    = 1'b1;
                h_d     = sum;
                state_d = INIT;
                if (!hash_sel_q && !block_sel_q) begin
                    block_sel_d = 1'b1;
                end else if (!hash_sel_q) begin
                    // End of pass 0: latch digest and restart chaining from the IV.
                    digest1_d   = sum;
                    h_d         = hash_values;
                    hash_sel_d  = 1'b1;
                    block_sel_d = 1'b0;
                end else begin
                    final_d = sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            h_q         <= '0;
            digest1_q   <= '0;
            final_q     <= '0;
            hash_sel_q  <= 1'b0;
            block_sel_q <= 1'b0;
            round_q     <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            digest1_q   <= digest1_d;
            final_q     <= final_d;
            hash_sel_q  <= hash_sel_d;
            block_sel_q <= block_sel_d;
            round_q     <= round_d;
        end
    end

    assign hash_sel   = hash_sel_q;
    assign block_sel  = block_sel_q;
    assign state_init = h_q;
    assign round_idx  = round_q;
    assign digest1    = digest1_q;
    assign final_hash = final_q;

endmodule
